// File: rtl/midi_rx.sv
// MIDI serial receiver (8N1) with channel-voice message assembler.
// Optional: define MIDI_RUNNING_STATUS_EN to keep status after a message.
module midi_rx #(
    parameter int BIT_CLKS = 1600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic       msg_valid
);

    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CLKS - 1);

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    localparam logic [1:0] P_WS  = 2'd0;
    localparam logic [1:0] P_WD1 = 2'd1;
    localparam logic [1:0] P_WD2 = 2'd2;

    logic          rxd_m_q, rxd_s;
    logic [2:0]    rx_q, rx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    bd_q, bd_d;
    logic          bv_q, bv_d;
    logic          fe_q, fe_d;

    logic [1:0]    ps_q, ps_d;
    logic [7:0]    stat_q, stat_d;
    logic [6:0]    d1_q, d1_d;
    logic [7:0]    ms_q, ms_d;
    logic [6:0]    m1_q, m1_d;
    logic [6:0]    m2_q, m2_d;
    logic          mv_q, mv_d;

    logic          is_sys, is_stat, is_data, done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m_q <= 1'b1;
            rxd_s   <= 1'b1;
        end else begin
            rxd_m_q <= rxd;
            rxd_s   <= rxd_m_q;
        end
    end

    // Each sample point reloads the cycle counter for the next bit centre.
    always_comb begin
        rx_d  = rx_q;
        cnt_d = cnt_q;
        bit_d = bit_q;
        sh_d  = sh_q;
        bd_d  = bd_q;
        bv_d  = 1'b0;
        fe_d  = 1'b0;
        case (rx_q)
            RX_IDLE: begin
                if (!rxd_s) begin
                    rx_d  = RX_START;
                    cnt_d = HALF_M1;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    cnt_d = FULL_M1;
                    bit_d = 4'd0;
                    rx_d  = rxd_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = FULL_M1;
                    sh_d  = {rxd_s, sh_q[7:1]};
                    if (bit_q == 4'd7) rx_d = RX_STOP;
                    else bit_d = bit_q + 4'd1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    if (rxd_s) begin
                        bv_d = 1'b1;
                        bd_d = sh_q;
                        rx_d = RX_IDLE;
                    end else begin
                        fe_d = 1'b1;
                        rx_d = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_BREAK: begin
                if (rxd_s) rx_d = RX_IDLE;
            end
            default: rx_d = RX_IDLE;
        endcase
    end

    assign is_sys  = (bd_q[7:3] == 5'b11110);
    assign is_stat = bd_q[7] && (bd_q[7:4] != 4'hF);
    assign is_data = !bd_q[7];

    always_comb begin
        ps_d   = ps_q;
        stat_d = stat_q;
        d1_d   = d1_q;
        ms_d   = ms_q;
        m1_d   = m1_q;
        m2_d   = m2_q;
        mv_d   = 1'b0;
        done   = 1'b0;
        if (bv_q) begin
            if (is_sys) begin
                stat_d = 8'h00;
                d1_d   = 7'd0;
                ps_d   = P_WS;
            end else if (is_stat) begin
                stat_d = bd_q;
                d1_d   = 7'd0;
                ps_d   = P_WD1;
            end else if (is_data && ps_q == P_WD1) begin
                d1_d = bd_q[6:0];
                if (stat_q[7:5] == 3'b110) begin
                    done = 1'b1;
                    m1_d = bd_q[6:0];
                    m2_d = 7'd0;
                end else begin
                    ps_d = P_WD2;
                end
            end else if (is_data && ps_q == P_WD2) begin
                done = 1'b1;
                m1_d = d1_q;
                m2_d = bd_q[6:0];
            end
        end
        if (done) begin
            mv_d = 1'b1;
            ms_d = stat_q;
`ifdef MIDI_RUNNING_STATUS_EN
            ps_d = P_WD1;
`else
            ps_d   = P_WS;
            stat_d = 8'h00;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q   <= RX_IDLE;
            cnt_q  <= '0;
            bit_q  <= 4'd0;
            sh_q   <= 8'h00;
            bd_q   <= 8'h00;
            bv_q   <= 1'b0;
            fe_q   <= 1'b0;
            ps_q   <= P_WS;
            stat_q <= 8'h00;
            d1_q   <= 7'd0;
            ms_q   <= 8'h00;
            m1_q   <= 7'd0;
            m2_q   <= 7'd0;
            mv_q   <= 1'b0;
        end else begin
            rx_q   <= rx_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            bd_q   <= bd_d;
            bv_q   <= bv_d;
            fe_q   <= fe_d;
            ps_q   <= ps_d;
            stat_q <= stat_d;
            d1_q   <= d1_d;
            ms_q   <= ms_d;
            m1_q   <= m1_d;
            m2_q   <= m2_d;
            mv_q   <= mv_d;
        end
    end

    assign byte_data  = bd_q;
    assign byte_valid = bv_q;
    assign frame_err  = fe_q;
    assign msg_status = ms_q;
    assign msg_data1  = m1_q;
    assign msg_data2  = m2_q;
    assign msg_valid  = mv_q;

endmodule

// File: tb/tb_midi_rx.sv
// Scoreboard bench for midi_rx at BIT_CLKS=16.
// Expected bytes/messages are queued as frames are driven.
module tb_midi_rx;

    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic       msg_valid;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_bv = -10;
    int fe_cnt = 0;

    logic [7:0]  bq[$];
    logic [21:0] mq[$];

    midi_rx #(.BIT_CLKS(BIT)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd),
        .byte_data(byte_data), .byte_valid(byte_valid),
        .frame_err(frame_err), .msg_status(msg_status),
        .msg_data1(msg_data1), .msg_data2(msg_data2),
        .msg_valid(msg_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every strobe
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid) begin
                n_cmp++;
                if (bq.size() == 0) begin
                    n_err++;
                    $display("FAIL byte_unexpected got %02h required none", byte_data);
                end else begin
                    logic [7:0] eb;
                    eb = bq.pop_front();
                    if (byte_data !== eb) begin
                        n_err++;
                        $display("FAIL byte_data got %02h required %02h", byte_data, eb);
                    end
                end
                last_bv = cyc;
            end
            if (frame_err) fe_cnt++;
            if (msg_valid) begin
                n_cmp++;
                if (mq.size() == 0) begin
                    n_err++;
                    $display("FAIL msg_unexpected got %02h/%02h/%02h required none",
                             msg_status, msg_data1, msg_data2);
                end else begin
                    logic [21:0] em;
                    em = mq.pop_front();
                    if ({msg_status, msg_data1, msg_data2} !== em) begin
                        n_err++;
                        $display("FAIL msg got %02h/%02h/%02h required %02h/%02h/%02h",
                                 msg_status, msg_data1, msg_data2,
                                 em[21:14], em[13:7], em[6:0]);
                    end
                end
                n_cmp++;
                if (cyc !== last_bv + 1) begin
                    n_err++;
                    $display("FAIL msg_latency got %0d required %0d", cyc - last_bv, 1);
                end
            end
        end
    end

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bq.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic exp_msg(input logic [7:0] s, input logic [6:0] a, input logic [6:0] b);
        mq.push_back({s, a, b});
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((bq.size() != 0 || mq.size() != 0) && k < 2000) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (bq.size() != 0 || mq.size() != 0) begin
            n_err++;
            $display("FAIL %s_pending got %0d bytes %0d msgs required 0 0",
                     nm, bq.size(), mq.size());
        end
        bq.delete();
        mq.delete();
    endtask

    task automatic check_idle_outputs(input string nm);
        n_cmp++;
        if ({byte_data, byte_valid, frame_err} !== 10'd0) begin
            n_err++;
            $display("FAIL %s_byte got %02h/%b/%b required 00/0/0",
                     nm, byte_data, byte_valid, frame_err);
        end
        n_cmp++;
        if ({msg_status, msg_data1, msg_data2, msg_valid} !== 23'd0) begin
            n_err++;
            $display("FAIL %s_msg got %02h/%02h/%02h/%b required 00/00/00/0",
                     nm, msg_status, msg_data1, msg_data2, msg_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_idle_outputs("post_reset");
    endtask

    task automatic test_note_on();
        exp_msg(8'h90, 7'h3C, 7'h64);
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'h64);
        drain("note_on");
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_byte(8'h80);
        drain("glitch");
        n_cmp++;
        if (fe_cnt !== fe0) begin
            n_err++;
            $display("FAIL glitch_fe got %0d required %0d", fe_cnt - fe0, 0);
        end
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h45, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        n_cmp++;
        if (fe_cnt !== fe0 + 1) begin
            n_err++;
            $display("FAIL frame_err_count got %0d required %0d", fe_cnt - fe0, 1);
        end
        exp_msg(8'hC5, 7'h07, 7'h00);
        send_byte(8'hC5);
        send_byte(8'h07);
        drain("frame_err");
    endtask

    task automatic test_realtime();
        exp_msg(8'h90, 7'h3C, 7'h64);
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'hF8);
        send_byte(8'h64);
        drain("realtime");
    endtask

    task automatic test_running_status();
        exp_msg(8'h90, 7'h3C, 7'h64);
`ifdef MIDI_RUNNING_STATUS_EN
        exp_msg(8'h90, 7'h40, 7'h00);
`endif
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'h64);
        send_byte(8'h40);
        send_byte(8'h00);
        drain("running_status");
    endtask

    task automatic test_reset_midframe();
        int fe0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rxd = 1'b1;
        repeat (BIT / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("midframe_rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fe0 = fe_cnt;
        for (int i = 0; i < 12; i++) drive_bit(1'b1);
        n_cmp++;
        if (fe_cnt !== fe0) begin
            n_err++;
            $display("FAIL midframe_fe got %0d required %0d", fe_cnt - fe0, 0);
        end
        check_idle_outputs("midframe_quiet");
        exp_msg(8'h80, 7'h3C, 7'h00);
        send_byte(8'h80);
        send_byte(8'h3C);
        send_byte(8'h00);
        drain("midframe_next");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_note_on();
        test_glitch();
        test_frame_err();
        test_realtime();
        test_running_status();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
